// File: rtl/cordic_sched_pkg.sv
`default_nettype none
// ============================================================================
// cordic_sched_pkg : shared types and constants for the cordic scheduler
// Rev 1.0
// ============================================================================
package cordic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    BUSY = 2'd2
  } state_e;

  localparam int CORDIC_LAST_IDX = 9;
  localparam int CORDIC_WORD_W   = 32;
  localparam int IDX_W           = 4;

endpackage
`default_nettype wire

// File: rtl/cordic_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot grant, search starts at ptr_i and wraps
// Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  always_comb begin
    logic found;
    int   pos;
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[pos[PTR_W-1:0]]) begin
        grant_o[pos[PTR_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_scheduler.sv
`default_nettype none
// ============================================================================
// cordic_scheduler : time-shares one 10-cycle cordic unit among NUM_REQ users
// Rev 1.0
// ============================================================================
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                               clock,
  input  logic                               aclr,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [CORDIC_WORD_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [CORDIC_WORD_W-1:0]           resp_data,
  output logic                               cordic_aclr,
  output logic                               cordic_clk_en,
  output logic [CORDIC_WORD_W-1:0]           cordic_dataa,
  input  logic [CORDIC_WORD_W-1:0]           cordic_result,
  output logic                               busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         inflight_q, inflight_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic                     pend_q, pend_d;
  logic [CORDIC_WORD_W-1:0] resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0]       w_grant;
  logic [PTR_W-1:0]         w_win_idx;
  logic [CORDIC_WORD_W-1:0] w_win_data;
  logic                     w_run, w_last, w_accept, w_capture;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (w_grant)
  );

  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx  = PTR_W'(i);
        w_win_data = req_data[i*CORDIC_WORD_W +: CORDIC_WORD_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    inflight_d  = inflight_q;
    owner_d     = owner_q;
    pend_d      = 1'b0;
    resp_data_d = resp_data_q;

    w_run         = (state_q != IDLE);
    w_last        = (idx_q == IDX_W'(CORDIC_LAST_IDX));
    cordic_aclr   = w_run ? aclr : 1'b1;
    cordic_clk_en = w_run && !aclr;
    busy          = w_run && !aclr;
    w_accept      = w_run && w_last && (|req_valid) && !aclr;
    w_capture     = (state_q == BUSY) && w_last && !aclr;

    // idx mirrors the cordic's internal iteration counter, which its reset clears
    if (cordic_aclr || w_last) idx_d = '0;
    else                       idx_d = idx_q + 1'b1;

    case (state_q)
      IDLE:       if (|req_valid) state_d = WARM;
      WARM, BUSY: if (w_last)     state_d = w_accept ? BUSY : IDLE;
      default:                    state_d = IDLE;
    endcase

    if (w_accept) begin
      ptr_d      = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
      inflight_d = w_win_idx;
    end

    if (w_capture) begin
      owner_d     = inflight_q;
      pend_d      = 1'b1;
      resp_data_d = cordic_result;
    end

    req_ready    = w_accept ? w_grant : '0;
    cordic_dataa = w_accept ? w_win_data : '0;
  end

  always_comb begin
    resp_valid = '0;
    if (pend_q) resp_valid[owner_q] = 1'b1;
  end

  assign resp_data = resp_data_q;

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      inflight_q  <= '0;
      owner_q     <= '0;
      pend_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      owner_q     <= owner_d;
      pend_q      <= pend_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters sharing one cordic unit (2..8).
REQ-002 Port: clock  in  1  sole clock, all logic on rising edge.
REQ-003 Port: aclr  in  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  in  NUM_REQ  per-requester request valid.
REQ-005 Port: req_data  in  32*NUM_REQ  per-requester IEEE-754 single angle, slice i = bits [32i+31:32i].
REQ-006 Port: req_ready  out  NUM_REQ  one-hot accept strobe.
REQ-007 Port: resp_valid  out  NUM_REQ  one-hot result strobe, one cycle per accepted request.
REQ-008 Port: resp_data  out  32  fixed-point cosine result for the strobed requester.
REQ-009 Port: cordic_aclr  out  1  reset to the shared cordic unit.
REQ-010 Port: cordic_clk_en  out  1  enable to the shared cordic unit.
REQ-011 Port: cordic_dataa  out  32  operand to the shared cordic unit.
REQ-012 Port: cordic_result  in  32  result from the shared cordic unit.
REQ-013 Port: busy  out  1  high whenever state != IDLE.

Function
REQ-014 Requester handshake: req_valid[i] and req_data slice i are held stable until req_ready[i]. Transfer occurs in the cycle where both are high.
REQ-015 Mirror counter idx (0..9) tracks the cordic iteration index.
  - Forced to 0 while cordic_aclr=1.
  - Otherwise increments each cycle, wrapping 9->0.
REQ-016 States and outputs:
  - IDLE: cordic held in reset. cordic_aclr=1, cordic_clk_en=0.
  - WARM: cordic running, no operation in flight.
  - BUSY: one operation in flight.
  - In WARM and BUSY: cordic_aclr=aclr, cordic_clk_en=1.
REQ-017 IDLE->WARM on the cycle after any req_valid bit is high. The first WARM cycle has idx=0.
REQ-018 Acceptance only in WARM or BUSY cycles with idx==9 and |req_valid.
  - req_ready[w]=1 for the arbitration winner w.
  - cordic_dataa = req_data slice w, combinationally, in that cycle.
REQ-019 In any other cycle, req_ready=0 and cordic_dataa=0.
REQ-020 WARM at idx==9: accept the winner and go to BUSY if any request is valid, else go to IDLE.
REQ-021 BUSY at idx==9: capture cordic_result and the owner index.
  - Same cycle: accept a new winner and stay BUSY if any request is valid, else go to IDLE.
  - Capture and new accept in the same cycle are both legal and required.
REQ-022 On the cycle after a BUSY idx==9 cycle: resp_valid[owner]=1 for exactly one cycle, and resp_data=captured value. resp_data holds that value until the next capture.
REQ-023 Timing from a request raised in IDLE at cycle t: req_ready at t+10, result capture at t+20, resp_valid at t+21.
REQ-024 Steady-state throughput is one operation per 10 cycles. Accept-to-response latency is 11 cycles.
REQ-025 Arbitration is round-robin.
  - Pointer p starts at 0 (requester 0 has highest priority).
  - On each accept of w, p = (w+1) mod NUM_REQ.
  - Search order is p, p+1, ... with wrap-around.
  - Requests not valid at an idx==9 cycle are not considered.
REQ-026 At most one requester is accepted per cordic pass. At most one operation is in flight.

Reset
REQ-027 While aclr=1, on the next edge:
  - State becomes IDLE; idx=0; p=0.
  - resp_valid=0; resp_data=0; captured owner=0.
REQ-028 Combinational outputs during aclr=1: req_ready=0, cordic_aclr=1, cordic_clk_en=0, busy=0.
REQ-029 Reset mid-operation drops the in-flight operation: no resp_valid is ever produced for it.

Structure
REQ-030 Shared package cordic_sched_pkg holds:
  - State enum (IDLE, WARM, BUSY).
  - Constants CORDIC_LAST_IDX=9 and CORDIC_WORD_W=32.
REQ-031 Round-robin grant logic is one sub-module, rr_arbiter.
  - Inputs: request vector, pointer.
  - Output: one-hot grant.
  - Parameterised by NUM_REQ.

Verification
REQ-032 Single request: req_valid[0]=1, data 0x3F800000 at cycle 0 from IDLE -> req_ready[0] at cycle 10, cordic_dataa=0x3F800000 at cycle 10, resp_valid[0] at cycle 21 equal to cordic_result sampled at cycle 20, IDLE at cycle 21.
REQ-033 Simultaneous pair: req_valid=4'b0011 at cycle 0 -> req_ready[0] at 10, req_ready[1] at 20, resp_valid[0] at 21, resp_valid[1] at 31.
REQ-034 Fairness: all four requests held continuously valid -> accept order 0,1,2,3,0 at cycles 10,20,30,40,50, and no requester is skipped.
REQ-035 Reset mid-operation: request at cycle 0, aclr=1 at cycle 15 for one cycle -> no resp_valid at any cycle, cordic_aclr=1 at cycle 15, state IDLE at cycle 16, p=0.
REQ-036 Idle return and restart: after the last response, cordic_aclr=1 and cordic_clk_en=0. A new req_valid[2] raised 5 cycles later at cycle u -> req_ready[2] at exactly u+10.
REQ-037 Back-to-back with capture: requester 3 raises req_valid at the same idx==9 cycle as requester 1's result capture -> resp for 1 and accept of 3 both occur, busy stays high.
